// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 hazard/forwarding unit.
package hazard_pkg;

   localparam int REG_AW = 5;
   localparam int FWD_RF = 0;

   // One in-flight instruction as seen by the scoreboard.
   typedef struct packed {
      logic              valid;
      logic              we;
      logic              is_load;
      logic [REG_AW-1:0] rd;
   } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against every scoreboard slot; one hit bit per slot.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic [REG_AW-1:0] src,
   input  logic              used,
   input  slot_t [DEPTH-1:0] slots,
   output logic [DEPTH-1:0]  hit
);

   always_comb begin
      hit = '0;
      for (int j = 0; j < DEPTH; j++) begin
         // x0 is hardwired to zero, so it never produces a dependency.
         hit[j] = slots[j].valid & slots[j].we & (slots[j].rd == src) & (src != '0) & used;
      end
   end

endmodule

// File: rtl/rv_hazard_unit.sv
// Hazard/forwarding controller: shift scoreboard, load-use stall, EX forwarding, redirect flush.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_cycles performance counters.
module rv_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = hazard_pkg::REG_AW,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              redirect,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic [SEL_W-1:0]  fwd_a,
   output logic [SEL_W-1:0]  fwd_b
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles
`endif
);

   slot_t [DEPTH-1:0]       slot_q, slot_d;
   logic [REG_AW-1:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic                    ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;

   logic [3:0][REG_AW-1:0]  m_src;
   logic [3:0]              m_used;
   logic [3:0][DEPTH-1:0]   m_hit;
   logic [DEPTH-1:0]        ld_block, fwd_ok;
   logic                    load_use, stall, redir, enter;

   // Sources 0/1 are the decode operands, 2/3 the operands of the instruction now in EX.
   assign m_src  = {ex_rs2_q, ex_rs1_q, id_rs2, id_rs1};
   assign m_used = {ex_rs2_used_q, ex_rs1_used_q, id_rs2_used, id_rs1_used};

   for (genvar s = 0; s < 4; s++) begin : g_match
      hazard_match #(.DEPTH(DEPTH)) u_match (
         .src   (m_src[s]),
         .used  (m_used[s]),
         .slots (slot_q),
         .hit   (m_hit[s])
      );
   end

   always_comb begin
      ld_block = '0;
      fwd_ok   = '0;
      for (int j = 0; j < DEPTH; j++) begin
         ld_block[j] = slot_q[j].is_load && (j + 1 < LOAD_STAGE);
         fwd_ok[j]   = (j != 0) && !(slot_q[j].is_load && (j < LOAD_STAGE));
      end
   end

   assign load_use = |((m_hit[0] | m_hit[1]) & ld_block);
   assign stall    = id_valid & load_use;
   assign redir    = redirect & rst_n;
   assign enter    = id_valid & ~stall & ~redir;

   // Redirect wins over a pending stall: the stalled instruction is on the wrong path anyway.
   assign stall_f = stall & ~redir;
   assign stall_d = stall & ~redir;
   assign flush_d = redir;
   assign flush_e = redir | stall;

   always_comb begin
      fwd_a = SEL_W'(FWD_RF);
      fwd_b = SEL_W'(FWD_RF);
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (m_hit[2][k] && fwd_ok[k]) fwd_a = SEL_W'(k);
         if (m_hit[3][k] && fwd_ok[k]) fwd_b = SEL_W'(k);
      end
   end

   always_comb begin
      slot_d = '0;
      for (int i = 1; i < DEPTH; i++) slot_d[i] = slot_q[i-1];
      ex_rs1_d      = '0;
      ex_rs2_d      = '0;
      ex_rs1_used_d = 1'b0;
      ex_rs2_used_d = 1'b0;
      if (enter) begin
         slot_d[0].valid   = 1'b1;
         slot_d[0].we      = id_we;
         slot_d[0].is_load = id_is_load;
         slot_d[0].rd      = id_rd;
         ex_rs1_d          = id_rs1;
         ex_rs2_d          = id_rs2;
         ex_rs1_used_d     = id_rs1_used;
         ex_rs2_used_d     = id_rs2_used;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q        <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rs1_used_q <= 1'b0;
         ex_rs2_used_q <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rs1_used_q <= ex_rs1_used_d;
         ex_rs2_used_q <= ex_rs2_used_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(stall_f);
      flush_cnt_d = flush_cnt_q + 32'(redir);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`endif

endmodule
